// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic ops, serial shifts, radix-2 Booth multiply
// and signed restoring divide, all sharing one work register set behind a small FSM.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 2) + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_NEG  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SHRA = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_DIV = CW'(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_MUL, S_DIV, S_FIX} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  work_lo;
    logic [WIDTH:0]    work_hi;
    logic [WIDTH-1:0]  m_reg;
    logic              qm1;
    logic              dz;
    logic              neg_q;
    logic              neg_r;

    logic [CW-1:0]     shamt;
    logic              is_shift;
    logic [WIDTH-1:0]  simple_lo;
    logic [WIDTH-1:0]  simple_hi;
    logic [WIDTH:0]    add_w;
    logic [WIDTH:0]    sub_w;
    logic [WIDTH-1:0]  shift_nxt;
    logic [WIDTH:0]    m_ext;
    logic [WIDTH:0]    booth_sum;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH:0]    rem_diff;
    logic [WIDTH-1:0]  fix_lo;
    logic [WIDTH-1:0]  fix_hi;
    logic              fix_dbz;

    assign shamt    = {{(CW-SHW){1'b0}}, b[SHW-1:0]};
    assign is_shift = (op >= OP_SHR) && (op <= OP_ROL);
    assign add_w    = {1'b0, a} + {1'b0, b};
    assign sub_w    = {1'b0, a} - {1'b0, b};
    assign m_ext    = {m_reg[WIDTH-1], m_reg};

    // Single-cycle results, computed straight from the inputs at acceptance
    always_comb begin
        simple_lo = '0;
        simple_hi = '0;
        case (op)
            OP_ADD: begin
                simple_lo = add_w[WIDTH-1:0];
                simple_hi = {{(WIDTH-1){1'b0}}, add_w[WIDTH]};
            end
            OP_SUB: begin
                simple_lo = sub_w[WIDTH-1:0];
                simple_hi = {{(WIDTH-1){1'b0}}, ~sub_w[WIDTH]};
            end
            OP_AND:  simple_lo = a & b;
            OP_OR:   simple_lo = a | b;
            OP_NOT:  simple_lo = ~b;
            OP_NEG:  simple_lo = -b;
            default: simple_lo = '0;
        endcase
    end

    // One-step datapath for the iterative states
    always_comb begin
        case (op_q)
            OP_SHR:  shift_nxt = {1'b0, work_lo[WIDTH-1:1]};
            OP_SHRA: shift_nxt = {work_lo[WIDTH-1], work_lo[WIDTH-1:1]};
            OP_SHL:  shift_nxt = {work_lo[WIDTH-2:0], 1'b0};
            OP_ROR:  shift_nxt = {work_lo[0], work_lo[WIDTH-1:1]};
            OP_ROL:  shift_nxt = {work_lo[WIDTH-2:0], work_lo[WIDTH-1]};
            default: shift_nxt = work_lo;
        endcase
        case ({work_lo[0], qm1})
            2'b01:   booth_sum = work_hi + m_ext;
            2'b10:   booth_sum = work_hi - m_ext;
            default: booth_sum = work_hi;
        endcase
        rem_sh   = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, m_reg};
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_shift)         state_nxt = (shamt == '0) ? S_FIX : S_SHIFT;
                    else if (op == OP_MUL) state_nxt = S_MUL;
                    else if (op == OP_DIV) state_nxt = S_DIV;
                    else                   state_nxt = S_FIX;
                end
            end
            S_SHIFT, S_MUL: if (cnt == CNT_ONE) state_nxt = S_FIX;
            S_DIV: begin
                // The first DIV cycle prepares magnitudes; a zero divisor skips the loop
                if ((cnt == CNT_DIV && m_reg == '0) || cnt == CNT_ONE) state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != S_IDLE);
        fix_lo  = work_lo;
        fix_hi  = work_hi[WIDTH-1:0];
        fix_dbz = 1'b0;
        if (op_q == OP_DIV) begin
            if (dz) begin
                fix_lo  = '0;
                fix_hi  = work_lo;
                fix_dbz = 1'b1;
            end else begin
                fix_lo = neg_q ? -work_lo : work_lo;
                fix_hi = neg_r ? -work_hi[WIDTH-1:0] : work_hi[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt     <= '0;
            op_q    <= '0;
            work_lo <= '0;
            work_hi <= '0;
            m_reg   <= '0;
            qm1     <= 1'b0;
            dz      <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        m_reg   <= b;
                        qm1     <= 1'b0;
                        dz      <= 1'b0;
                        neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_r   <= a[WIDTH-1];
                        work_lo <= simple_lo;
                        work_hi <= {1'b0, simple_hi};
                        cnt     <= '0;
                        if (is_shift) begin
                            work_lo <= a;
                            work_hi <= '0;
                            cnt     <= shamt;
                        end else if (op == OP_MUL) begin
                            work_lo <= a;
                            work_hi <= '0;
                            cnt     <= CNT_MUL;
                        end else if (op == OP_DIV) begin
                            work_lo <= a;
                            work_hi <= '0;
                            cnt     <= CNT_DIV;
                        end
                    end
                end
                S_SHIFT: begin
                    work_lo <= shift_nxt;
                    cnt     <= cnt - CNT_ONE;
                end
                S_MUL: begin
                    // Arithmetic shift right of {acc, multiplier, q-1}
                    work_hi <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    work_lo <= {booth_sum[0], work_lo[WIDTH-1:1]};
                    qm1     <= work_lo[0];
                    cnt     <= cnt - CNT_ONE;
                end
                S_DIV: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_DIV) begin
                        if (m_reg == '0) begin
                            dz <= 1'b1;
                        end else begin
                            work_lo <= work_lo[WIDTH-1] ? -work_lo : work_lo;
                            m_reg   <= m_reg[WIDTH-1] ? -m_reg : m_reg;
                            work_hi <= '0;
                        end
                    end else if (!rem_diff[WIDTH]) begin
                        work_hi <= rem_diff;
                        work_lo <= {work_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        work_hi <= rem_sh;
                        work_lo <= {work_lo[WIDTH-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // Visible results change only on the FIX -> IDLE transition
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == S_FIX);
            if (state == S_FIX) begin
                result_lo   <= fix_lo;
                result_hi   <= fix_hi;
                div_by_zero <= fix_dbz;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: driver pushes model results with due cycle,
// monitor checks done/busy every cycle and results on each done.
module tb_multicycle_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clear_n = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_by_zero;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from the operation definitions, using plain arithmetic
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic dbz, output int lat);
        logic [63:0] wide;
        longint      p;
        int          n, sx, sy;
        lo = '0; hi = '0; dbz = 1'b0; lat = 1;
        n  = int'(y % 32);
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            4'd0: begin wide = 64'(x) + 64'(y); lo = wide[31:0]; hi = 32'(wide[32]); end
            4'd1: begin lo = x - y; hi = (x >= y) ? 32'd1 : 32'd0; end
            4'd2: lo = x & y;
            4'd3: lo = x | y;
            4'd4: lo = ~y;
            4'd5: lo = -y;
            4'd6: begin lo = x >> n; lat = n + 1; end
            4'd7: begin lo = $signed(x) >>> n; lat = n + 1; end
            4'd8: begin lo = x << n; lat = n + 1; end
            4'd9: begin lo = (n == 0) ? x : ((x >> n) | (x << (32 - n))); lat = n + 1; end
            4'd10: begin lo = (n == 0) ? x : ((x << n) | (x >> (32 - n))); lat = n + 1; end
            4'd11: begin
                p = longint'(sx) * longint'(sy);
                wide = p;
                lo = wide[31:0]; hi = wide[63:32]; lat = 33;
            end
            4'd12: begin
                if (y == 0) begin
                    lo = 0; hi = x; dbz = 1'b1; lat = 2;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    lo = x; hi = 0; lat = 34;
                end else begin
                    lo = sx / sy; hi = sx % sy; lat = 34;
                end
            end
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin
        if (clear_n) begin
            logic exp_done;
            exp_done = (sb.size() > 0) && (sb[0].due == cyc);
            chk("done_timing", 64'(done), 64'(exp_done));
            chk("busy", 64'(busy), 64'((sb.size() > 0) && !exp_done));
            if (exp_done && done) begin
                chk("result_lo", 64'(result_lo), 64'(sb[0].lo));
                chk("result_hi", 64'(result_hi), 64'(sb[0].hi));
                chk("div_by_zero", 64'(div_by_zero), 64'(sb[0].dbz));
            end
            if (sb.size() > 0 && cyc >= sb[0].due) void'(sb.pop_front());
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_lo"}, 64'(result_lo), 64'(0));
        chk({tag, "_hi"}, 64'(result_hi), 64'(0));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(0));
    endtask

    // Called at a negedge with busy low; returns just after the accepting edge
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int k);
        exp_t e;
        int   lat;
        model(o, x, y, e.lo, e.hi, e.dbz, lat);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        k = cyc;
        e.due = k + lat;
        sb.push_back(e);
        start = 1'b0;
        op = 4'($urandom); a = $urandom; b = $urandom;
    endtask

    // Waits for busy low, optionally throwing ignored start pulses meanwhile
    task automatic wait_idle(input bit junk);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                start = 1'b0;
                return;
            end
            if (junk) begin
                start = 1'($urandom);
                op = 4'($urandom); a = $urandom; b = $urandom;
            end
        end
        start = 1'b0;
        n_checks++;
        n_fail++;
        $display("FAIL idle_timeout: busy still 1 after 200 cycles, required 0");
    endtask

    initial begin
        int k;
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;

        #1 clear_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, k);
        wait_idle(1);
        issue(4'd7, 32'h8000_0000, 32'h0000_0024, k);
        wait_idle(1);
        issue(4'd11, 32'hFFFF_FFFD, 32'h0000_0007, k);
        wait_idle(1);
        issue(4'd12, 32'hFFFF_FFF9, 32'h0000_0002, k);
        wait_idle(1);
        issue(4'd12, 32'h0000_0005, 32'h0000_0000, k);
        wait_idle(1);
        issue(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, k);
        wait_idle(1);
        issue(4'd11, 32'h8000_0000, 32'h8000_0000, k);
        wait_idle(1);
        issue(4'd1, 32'h0000_0003, 32'h0000_0005, k);
        wait_idle(1);
        issue(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, k);
        wait_idle(1);
        issue(4'd10, 32'h8000_0001, 32'hFFFF_FFE0, k);
        wait_idle(1);

        // Reset in the middle of a multiply
        issue(4'd11, 32'h0000_1234, 32'h0000_5678, k);
        repeat (11) @(negedge clk);
        clear_n = 1'b0;
        sb.delete();
        #1 check_zero("midreset");
        @(negedge clk);
        clear_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(4'd0, 32'd2, 32'd3, k);
        wait_idle(1);

        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = '0;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            issue(ro, ra, rb, k);
            wait_idle(1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
